mem_port_arbiter: RTL and testbench

- Shares one OBI-style memory port (req/gnt/rvalid) between the instruction-fetch requester and the data (load/store) requester.
- Sits between the fetch unit / LSU and the single memory interface.
- Arbitrates requests, keeps the downstream request stable until granted, and tracks outstanding transactions in issue order so each rvalid/rdata returns to its originator.
- Grant is combinational, so requesters see gnt in the same cycle as req.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_owner_fifo.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter and its owner FIFO.
// Owner bit values, hold-state encoding and the fixed byte-enable used for fetches.
package mem_arb_pkg;

    // Owner bit stored in the in-order FIFO for every granted transaction
    localparam logic OWN_INS = 1'b0;
    localparam logic OWN_DAT = 1'b1;

    // Instruction fetches always read a full word
    localparam logic [3:0] BE_FULL = 4'b1111;

    // Hold state: which requester is locked in while its request waits for a grant
    typedef enum logic [1:0] {
        S_FREE     = 2'd0,
        S_HOLD_INS = 2'd1,
        S_HOLD_DAT = 2'd2
    } hold_state_e;

    // Hold state that locks in the given owner
    function automatic hold_state_e holdFor(input logic owner);
        return (owner == OWN_DAT) ? S_HOLD_DAT : S_HOLD_INS;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// owner_fifo: 1-bit-wide in-order FIFO recording which requester owns each
// accepted-but-unanswered memory transaction. Pointers wrap modulo DEPTH.
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pushOwner_i,
    input  logic             pop_i,
    output logic             headOwner_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] slots_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Pointer advance with explicit wrap so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Occupancy only changes when exactly one of push/pop happens
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage, pointers and occupancy; reset discards every tracked owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slots_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                slots_q[wrPtr_q] <= pushOwner_i;
                wrPtr_q          <= nextPtr(wrPtr_q);
            end
            if (pop_i) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            count_q <= count_d;
        end
    end

    assign headOwner_o = slots_q[rdPtr_q];
    assign full_o      = (count_q == DEPTH_CNT);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one OBI-style memory port between instruction fetch
// and the load/store unit. Grants are combinational, a waiting request is held
// on its owner until granted or withdrawn, and responses are routed back in
// issue order through owner_fifo.
// Optional build macro: MEM_ARB_STARVE_GUARD_EN forces an instruction grant
// after STARVE_LIMIT back-to-back data grants that kept fetch waiting.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int OUT_W           = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ins_req_i,
    input  logic [31:0]      ins_addr_i,
    output logic             ins_gnt_o,
    output logic             ins_rvalid_o,
    output logic [31:0]      ins_rdata_o,
    input  logic             dat_req_i,
    input  logic [31:0]      dat_addr_i,
    input  logic             dat_we_i,
    input  logic [3:0]       dat_be_i,
    input  logic [31:0]      dat_wdata_i,
    output logic             dat_gnt_o,
    output logic             dat_rvalid_o,
    output logic [31:0]      dat_rdata_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [OUT_W-1:0] outstanding_o,
    output logic             err_spurious_o
);

    // Elaboration-time sanity of the configuration
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : gBadDepth
        $error("mem_port_arbiter: MAX_OUTSTANDING must be 1..4");
    end
    if ((1 << OUT_W) <= MAX_OUTSTANDING) begin : gBadCountWidth
        $error("mem_port_arbiter: OUT_W too narrow for MAX_OUTSTANDING");
    end
    if (STARVE_LIMIT < 1) begin : gBadStarveLimit
        $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    hold_state_e holdState_q;
    logic        errSpurious_q;

    logic ownerSel;
    logic ownerReq;
    logic fifoFull;
    logic fifoEmpty;
    logic fifoHead;
    logic popValid;
    logic issueReq;
    logic memGrant;
    logic insGrant;
    logic datGrant;
    logic forceIns;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starveCnt_q;
    logic [STARVE_W-1:0] starveCnt_d;

    // Count data grants that left fetch waiting; any fetch grant starts over
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (insGrant) begin
            starveCnt_d = '0;
        end else if (datGrant && ins_req_i && (starveCnt_q != STARVE_MAX)) begin
            starveCnt_d = starveCnt_q + STARVE_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

    assign forceIns = (starveCnt_q == STARVE_MAX);
`else
    assign forceIns = 1'b0;
`endif

    // Pick the owner: a held owner keeps the port, otherwise data has priority
    always_comb begin
        ownerSel = OWN_INS;
        case (holdState_q)
            S_HOLD_INS: ownerSel = OWN_INS;
            S_HOLD_DAT: ownerSel = OWN_DAT;
            default: begin
                if (forceIns && ins_req_i) begin
                    ownerSel = OWN_INS;
                end else if (dat_req_i) begin
                    ownerSel = OWN_DAT;
                end else begin
                    ownerSel = OWN_INS;
                end
            end
        endcase
    end

    // A full FIFO blocks issue unless a response frees a slot this same cycle
    assign ownerReq = (ownerSel == OWN_DAT) ? dat_req_i : ins_req_i;
    assign popValid = mem_rvalid_i & ~fifoEmpty;
    assign issueReq = ownerReq & (~fifoFull | popValid);
    assign memGrant = issueReq & mem_gnt_i;
    assign insGrant = memGrant & (ownerSel == OWN_INS);
    assign datGrant = memGrant & (ownerSel == OWN_DAT);

    // Downstream request fields come from the owner, or are zero when idle
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (issueReq) begin
            if (ownerSel == OWN_DAT) begin
                mem_addr_o  = dat_addr_i;
                mem_we_o    = dat_we_i;
                mem_be_o    = dat_be_i;
                mem_wdata_o = dat_wdata_i;
            end else begin
                mem_addr_o  = ins_addr_i;
                mem_be_o    = BE_FULL;
            end
        end
    end

    // Hold FSM: lock in an ungranted owner until granted or it withdraws
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            holdState_q <= S_FREE;
        end else begin
            case (holdState_q)
                S_FREE: begin
                    if (issueReq && !mem_gnt_i) begin
                        holdState_q <= holdFor(ownerSel);
                    end
                end
                S_HOLD_INS: begin
                    if (mem_gnt_i || !ins_req_i) begin
                        holdState_q <= S_FREE;
                    end
                end
                S_HOLD_DAT: begin
                    if (mem_gnt_i || !dat_req_i) begin
                        holdState_q <= S_FREE;
                    end
                end
                default: holdState_q <= S_FREE;
            endcase
        end
    end

    // Sticky flag for a response that has no transaction to belong to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            errSpurious_q <= 1'b0;
        end else if (mem_rvalid_i && fifoEmpty) begin
            errSpurious_q <= 1'b1;
        end
    end

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (OUT_W)
    ) uOwnerFifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (memGrant),
        .pushOwner_i (ownerSel),
        .pop_i       (popValid),
        .headOwner_o (fifoHead),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty),
        .count_o     (outstanding_o)
    );

    assign mem_req_o      = issueReq;
    assign ins_gnt_o      = insGrant;
    assign dat_gnt_o      = datGrant;
    assign ins_rvalid_o   = popValid & (fifoHead == OWN_INS);
    assign dat_rvalid_o   = popValid & (fifoHead == OWN_DAT);
    assign ins_rdata_o    = ins_rvalid_o ? mem_rdata_i : '0;
    assign dat_rdata_o    = dat_rvalid_o ? mem_rdata_i : '0;
    assign err_spurious_o = errSpurious_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table of cycles, hand-written corner sequences
// and random traffic, all checked against expected values computed here.
module tb_mem_port_arbiter;

    localparam int MAX_OUT = 2;
    localparam int STARVE  = 4;

    typedef struct packed {
        logic        insReq;
        logic [31:0] insAddr;
        logic        datReq;
        logic [31:0] datAddr;
        logic        datWe;
        logic [3:0]  datBe;
        logic [31:0] datWdata;
        logic        memGnt;
        logic        memRvalid;
        logic [31:0] memRdata;
    } stim_t;

    typedef struct packed {
        logic        memReq;
        logic [31:0] memAddr;
        logic        memWe;
        logic [3:0]  memBe;
        logic [31:0] memWdata;
        logic        insGnt;
        logic        datGnt;
        logic        insRv;
        logic        datRv;
        logic [31:0] rdata;
        logic [1:0]  outstanding;
        logic        err;
    } expect_t;

    typedef struct packed {
        stim_t   s;
        expect_t e;
    } vector_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ins_req_i, dat_req_i, dat_we_i, mem_gnt_i, mem_rvalid_i;
    logic [31:0] ins_addr_i, dat_addr_i, dat_wdata_i, mem_rdata_i;
    logic [3:0]  dat_be_i;
    logic        ins_gnt_o, ins_rvalid_o, dat_gnt_o, dat_rvalid_o;
    logic        mem_req_o, mem_we_o, err_spurious_o;
    logic [31:0] ins_rdata_o, dat_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [1:0]  outstanding_o;

    int totalChecks  = 0;
    int passedChecks = 0;

    // Reference model state: owners in issue order, held owner (-1 = none)
    bit      ownQ[$];
    int      heldOwner;
    bit      modelErr;
    int      starveCnt;
    expect_t lastExp;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_OUTSTANDING (MAX_OUT),
        .OUT_W           (2),
        .STARVE_LIMIT    (STARVE)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ins_req_i      (ins_req_i),
        .ins_addr_i     (ins_addr_i),
        .ins_gnt_o      (ins_gnt_o),
        .ins_rvalid_o   (ins_rvalid_o),
        .ins_rdata_o    (ins_rdata_o),
        .dat_req_i      (dat_req_i),
        .dat_addr_i     (dat_addr_i),
        .dat_we_i       (dat_we_i),
        .dat_be_i       (dat_be_i),
        .dat_wdata_i    (dat_wdata_i),
        .dat_gnt_o      (dat_gnt_o),
        .dat_rvalid_o   (dat_rvalid_o),
        .dat_rdata_o    (dat_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .outstanding_o  (outstanding_o),
        .err_spurious_o (err_spurious_o)
    );

    // One comparison: count it, report it on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        ins_req_i    = s.insReq;
        ins_addr_i   = s.insAddr;
        dat_req_i    = s.datReq;
        dat_addr_i   = s.datAddr;
        dat_we_i     = s.datWe;
        dat_be_i     = s.datBe;
        dat_wdata_i  = s.datWdata;
        mem_gnt_i    = s.memGnt;
        mem_rvalid_i = s.memRvalid;
        mem_rdata_i  = s.memRdata;
    endtask

    task automatic checkExpected(input expect_t e, input string tag);
        checkOutput({tag, " mem_req"},     32'(mem_req_o),      32'(e.memReq));
        checkOutput({tag, " mem_addr"},    mem_addr_o,          e.memAddr);
        checkOutput({tag, " mem_we"},      32'(mem_we_o),       32'(e.memWe));
        checkOutput({tag, " mem_be"},      32'(mem_be_o),       32'(e.memBe));
        checkOutput({tag, " mem_wdata"},   mem_wdata_o,         e.memWdata);
        checkOutput({tag, " ins_gnt"},     32'(ins_gnt_o),      32'(e.insGnt));
        checkOutput({tag, " dat_gnt"},     32'(dat_gnt_o),      32'(e.datGnt));
        checkOutput({tag, " ins_rvalid"},  32'(ins_rvalid_o),   32'(e.insRv));
        checkOutput({tag, " dat_rvalid"},  32'(dat_rvalid_o),   32'(e.datRv));
        checkOutput({tag, " ins_rdata"},   ins_rdata_o,         e.insRv ? e.rdata : 32'h0);
        checkOutput({tag, " dat_rdata"},   dat_rdata_o,         e.datRv ? e.rdata : 32'h0);
        checkOutput({tag, " outstanding"}, 32'(outstanding_o),  32'(e.outstanding));
        checkOutput({tag, " err_spurious"},32'(err_spurious_o), 32'(e.err));
    endtask

    function automatic stim_t st(input bit iReq, input logic [31:0] iAddr, input bit dReq,
                                 input logic [31:0] dAddr, input bit dWe, input logic [3:0] dBe,
                                 input logic [31:0] dWdata, input bit gnt, input bit rv,
                                 input logic [31:0] rdata);
        return '{insReq: iReq, insAddr: iAddr, datReq: dReq, datAddr: dAddr, datWe: dWe,
                 datBe: dBe, datWdata: dWdata, memGnt: gnt, memRvalid: rv, memRdata: rdata};
    endfunction

    function automatic expect_t ex(input bit req, input logic [31:0] addr, input bit we,
                                   input logic [3:0] be, input logic [31:0] wdata, input bit iGnt,
                                   input bit dGnt, input bit iRv, input bit dRv,
                                   input logic [31:0] rdata, input logic [1:0] outst, input bit err);
        return '{memReq: req, memAddr: addr, memWe: we, memBe: be, memWdata: wdata, insGnt: iGnt,
                 datGnt: dGnt, insRv: iRv, datRv: dRv, rdata: rdata, outstanding: outst, err: err};
    endfunction

    function automatic bit starveForce();
`ifdef MEM_ARB_STARVE_GUARD_EN
        return starveCnt >= STARVE;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit modelOwner(input stim_t s);
        if (heldOwner >= 0) return heldOwner == 1;
        if (starveForce() && s.insReq) return 1'b0;
        return s.datReq;
    endfunction

    // Expected outputs this cycle from the arbitration and ordering rules
    function automatic expect_t modelEval(input stim_t s);
        expect_t e;
        bit owner, ownerReq, popOk;
        e        = '0;
        owner    = modelOwner(s);
        ownerReq = owner ? s.datReq : s.insReq;
        popOk    = s.memRvalid && (ownQ.size() > 0);
        e.memReq = ownerReq && ((ownQ.size() < MAX_OUT) || popOk);
        if (e.memReq) begin
            if (owner) begin
                e.memAddr  = s.datAddr;
                e.memWe    = s.datWe;
                e.memBe    = s.datBe;
                e.memWdata = s.datWdata;
            end else begin
                e.memAddr = s.insAddr;
                e.memBe   = 4'hF;
            end
        end
        e.insGnt = e.memReq && s.memGnt && !owner;
        e.datGnt = e.memReq && s.memGnt && owner;
        if (popOk) begin
            if (ownQ[0]) e.datRv = 1'b1;
            else         e.insRv = 1'b1;
            e.rdata = s.memRdata;
        end
        e.outstanding = 2'(ownQ.size());
        e.err         = modelErr;
        return e;
    endfunction

    // Advance the reference model across one clock edge
    task automatic modelUpdate(input stim_t s, input expect_t e);
        bit owner;
        owner = modelOwner(s);
        if (s.memRvalid && ownQ.size() == 0) modelErr = 1'b1;
        if (e.insRv || e.datRv) void'(ownQ.pop_front());
        if (e.insGnt || e.datGnt) ownQ.push_back(e.datGnt);
        if (heldOwner < 0) begin
            if (e.memReq && !s.memGnt) heldOwner = owner ? 1 : 0;
        end else if (s.memGnt || !(owner ? s.datReq : s.insReq)) begin
            heldOwner = -1;
        end
        if (e.insGnt) starveCnt = 0;
        else if (e.datGnt && s.insReq && starveCnt < STARVE) starveCnt++;
    endtask

    task automatic modelReset();
        ownQ.delete();
        heldOwner = -1;
        modelErr  = 1'b0;
        starveCnt = 0;
    endtask

    task automatic evalCycle(input stim_t s, input string tag);
        applyStimulus(s);
        #3;
        lastExp = modelEval(s);
        checkExpected(lastExp, tag);
    endtask

    task automatic endCycle(input stim_t s);
        @(posedge clk);
        modelUpdate(s, lastExp);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus('0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelReset();
    endtask

    function automatic stim_t randStim();
        stim_t s;
        s.insReq    = 1'($urandom_range(0, 1));
        s.insAddr   = $urandom & 32'hFFFF_FFFC;
        s.datReq    = 1'($urandom_range(0, 1));
        s.datAddr   = $urandom;
        s.datWe     = 1'($urandom_range(0, 1));
        s.datBe     = 4'($urandom_range(0, 15));
        s.datWdata  = $urandom;
        s.memGnt    = ($urandom_range(0, 3) != 0);
        s.memRvalid = (ownQ.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
        s.memRdata  = $urandom;
        return s;
    endfunction

    // Bound the whole run in case the flow ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t vecs[17];
        stim_t   s;
        stim_t   holdStim;

        vecs[0]  = '{st(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0),
                     ex(1, 32'h100, 0, 4'hF, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13),
                     ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h13, 1, 0)};
        vecs[2]  = '{st(1, 32'h104, 1, 32'h2000, 1, 4'hF, 32'hDEADBEEF, 1, 0, 0),
                     ex(1, 32'h2000, 1, 4'hF, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0, 0)};
        vecs[3]  = '{st(1, 32'h104, 0, 0, 0, 0, 0, 1, 0, 0),
                     ex(1, 32'h104, 0, 4'hF, 0, 1, 0, 0, 0, 0, 1, 0)};
        vecs[4]  = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001),
                     ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001, 2, 0)};
        vecs[5]  = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBBBB0002),
                     ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBBBB0002, 1, 0)};
        holdStim = st(1, 32'h200, 1, 32'h40, 0, 4'h3, 32'h12345678, 0, 0, 0);
        for (int i = 6; i <= 8; i++) begin
            vecs[i] = '{holdStim, ex(1, 32'h40, 0, 4'h3, 32'h12345678, 0, 0, 0, 0, 0, 0, 0)};
        end
        holdStim.memGnt = 1'b1;
        vecs[9]  = '{holdStim, ex(1, 32'h40, 0, 4'h3, 32'h12345678, 0, 1, 0, 0, 0, 0, 0)};
        vecs[10] = '{st(1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0),
                     ex(1, 32'h200, 0, 4'hF, 0, 1, 0, 0, 0, 0, 1, 0)};
        vecs[11] = '{st(1, 32'h204, 0, 0, 0, 0, 0, 1, 0, 0),
                     ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0)};
        vecs[12] = '{st(1, 32'h204, 0, 0, 0, 0, 0, 1, 1, 32'h11),
                     ex(1, 32'h204, 0, 4'hF, 0, 1, 0, 0, 1, 32'h11, 2, 0)};
        vecs[13] = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22),
                     ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h22, 2, 0)};
        vecs[14] = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33),
                     ex(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h33, 1, 0)};
        vecs[15] = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44),
                     ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[16] = '{st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                     ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};

        // Reset state while reset is still asserted
        reset_n = 1'b0;
        applyStimulus('0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset mem_req",     32'(mem_req_o),      32'h0);
        checkOutput("reset ins_gnt",     32'(ins_gnt_o),      32'h0);
        checkOutput("reset dat_gnt",     32'(dat_gnt_o),      32'h0);
        checkOutput("reset outstanding", 32'(outstanding_o),  32'h0);
        checkOutput("reset err",         32'(err_spurious_o), 32'h0);
        reset_n = 1'b1;

        // Directed cycle table: fetch, contention, hold, full, spurious
        $display("[TB] directed table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].s);
            #3;
            lastExp = modelEval(vecs[i].s);
            checkExpected(vecs[i].e, $sformatf("vec%0d", i));
            endCycle(vecs[i].s);
        end

        // Reset mid-transaction: FIFO dropped at once, late response is spurious
        $display("[TB] reset mid-transaction");
        s = st(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
        evalCycle(s, "rst issue");
        endCycle(s);
        applyStimulus('0);
        #2;
        checkOutput("rst pre outstanding", 32'(outstanding_o), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst async outstanding", 32'(outstanding_o),  32'h0);
        checkOutput("rst async err",         32'(err_spurious_o), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelReset();
        s = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
        evalCycle(s, "late rvalid");
        checkOutput("late ins_rvalid", 32'(ins_rvalid_o), 32'h0);
        endCycle(s);
        s = '0;
        evalCycle(s, "after late");
        checkOutput("late err sticky", 32'(err_spurious_o), 32'h1);
        endCycle(s);

        // Both requesters saturating the port with one response per cycle
        $display("[TB] sustained contention");
        doReset();
        for (int k = 0; k < 7; k++) begin
            s = st(1, 32'h400, 1, 32'h3000, 0, 4'hF, 32'h0, 1, (k != 0), 32'(k));
            evalCycle(s, $sformatf("contend%0d", k));
`ifdef MEM_ARB_STARVE_GUARD_EN
            checkOutput($sformatf("starve ins_gnt %0d", k), 32'(ins_gnt_o), 32'(k == 4));
`else
            checkOutput($sformatf("priority dat_gnt %0d", k), 32'(dat_gnt_o), 32'h1);
`endif
            endCycle(s);
        end

        // Random traffic against the reference model
        $display("[TB] random traffic");
        doReset();
        for (int n = 0; n < 400; n++) begin
            s = randStim();
            evalCycle(s, $sformatf("rnd%0d", n));
            endCycle(s);
        end

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
